// File: rtl/axil_palette_table.sv
// axil_palette_table: banked AXI4-Lite colour palette with per-port pixel lookups and tear-free bank swap
module axil_palette_table #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] OFFSET = '0,
  parameter int DATA_WIDTH = 32,
  parameter int ENTRY_WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int NUM_BANKS = 2,
  parameter int NUM_PORTS = 2,
  localparam int IW = $clog2(DEPTH),
  localparam int FBW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]         s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [DATA_WIDTH-1:0]           s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  input  logic                            frame_sync,
  input  logic [NUM_PORTS-1:0]            lookup_valid,
  input  logic [NUM_PORTS*IW-1:0]         lookup_index,
  output logic [NUM_PORTS*ENTRY_WIDTH-1:0] lookup_data,
  output logic [NUM_PORTS-1:0]            lookup_data_valid,
  output logic [FBW-1:0]                  front_bank,
  output logic                            swap_done
);
  localparam int EPW = DATA_WIDTH / ENTRY_WIDTH;
  localparam int WPB = DEPTH / EPW;
  localparam int NW = NUM_BANKS * WPB;
  localparam int MW = $clog2(NW);
  localparam int AW2 = ADDR_WIDTH - 2;
  localparam logic [AW2-1:0] CTRL = AW2'(NW);
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_t;
  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  logic live_q, aw_held_q, aw_held_d, w_held_q, w_held_d, pend_q, pend_d, swap_done_q, swap_done_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d, req_q, req_d;
  logic [FBW-1:0] front_q, front_d;
  logic [NUM_PORTS*ENTRY_WIDTH-1:0] lookup_data_q, lookup_data_d;
  logic [NUM_PORTS-1:0] lookup_data_valid_q;
  logic [AW2-1:0] w_word, r_word;
  logic [MW-1:0] lk_word [NUM_PORTS];
  logic [DATA_WIDTH-1:0] mem [NW];
  logic w_commit, unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot};
  assign w_word = AW2'((aw_addr_q - OFFSET) >> 2);
  assign r_word = AW2'((ar_addr_q - OFFSET) >> 2);
  assign w_commit = w_state_q == W_COMMIT;
  assign s_axil_awready = live_q && w_state_q == W_IDLE && !aw_held_q;
  assign s_axil_wready = live_q && w_state_q == W_IDLE && !w_held_q;
  assign s_axil_bvalid = w_state_q == W_RESP;
  assign s_axil_bresp = bresp_q;
  assign s_axil_arready = live_q && r_state_q == R_IDLE;
  assign s_axil_rvalid = r_state_q == R_RESP;
  assign s_axil_rdata = rdata_q;
  assign s_axil_rresp = rresp_q;
  assign lookup_data = lookup_data_q;
  assign lookup_data_valid = lookup_data_valid_q;
  assign front_bank = front_q;
  assign swap_done = swap_done_q;
  // write channel: collect AW and W in any order, commit one cycle, then respond
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d = w_held_q;
    aw_addr_d = aw_addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    bresp_d = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axil_awvalid && s_axil_awready) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axil_awaddr;
        end
        if (s_axil_wvalid && s_axil_wready) begin
          w_held_d = 1'b1;
          wdata_d = s_axil_wdata;
          wstrb_d = s_axil_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_COMMIT;
          aw_held_d = 1'b0;
          w_held_d = 1'b0;
        end
      end
      W_COMMIT: begin
        w_state_d = W_RESP;
        bresp_d = w_word > CTRL ? 2'b10 : 2'b00;
      end
      W_RESP: w_state_d = s_axil_bready ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
  end
  // read channel: one access cycle, then hold the response until accepted
  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (r_state_q)
      R_IDLE: if (s_axil_arvalid) begin
        ar_addr_d = s_axil_araddr;
        r_state_d = live_q ? R_READ : R_IDLE;
      end
      R_READ: begin
        r_state_d = R_RESP;
        rdata_d = r_word < CTRL ? mem[MW'(r_word)] : r_word == CTRL ? DATA_WIDTH'({pend_q, 6'b0, req_q}) : '0;
        rresp_d = r_word > CTRL ? 2'b10 : 2'b00;
      end
      R_RESP: r_state_d = s_axil_rready ? R_IDLE : R_RESP;
      default: r_state_d = R_IDLE;
    endcase
  end
  // bank control: frame_sync sees the old request, a same-cycle write queues for the next frame
  always_comb begin
    swap_done_d = frame_sync && pend_q;
    front_d = swap_done_d ? FBW'(req_q) : front_q;
    pend_d = swap_done_d ? 1'b0 : pend_q;
    req_d = req_q;
    if (w_commit && w_word == CTRL && wstrb_q[0]) begin
      req_d = wdata_q[1:0];
      pend_d = pend_d | (wdata_q[1:0] != 2'(front_d));
    end
  end
  // pixel lookups read the front bank; idle ports keep their last entry
  always_comb begin
    lookup_data_d = lookup_data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      lk_word[p] = MW'(front_q) * MW'(WPB) + MW'(lookup_index[p*IW +: IW] / IW'(EPW));
      if (lookup_valid[p])
        lookup_data_d[p*ENTRY_WIDTH +: ENTRY_WIDTH] = ENTRY_WIDTH'(mem[lk_word[p]] >> (ENTRY_WIDTH * int'(lookup_index[p*IW +: IW] % IW'(EPW))));
    end
  end
  // byte-strobed palette storage, written only in the commit cycle so readers see old data
  always_ff @(posedge aclk)
    if (w_commit && w_word < CTRL)
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (wstrb_q[i]) mem[MW'(w_word)][8*i +: 8] <= wdata_q[8*i +: 8];
  // state registers
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      live_q <= 1'b0;
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      aw_addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bresp_q <= '0;
      r_state_q <= R_IDLE;
      ar_addr_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      req_q <= '0;
      pend_q <= 1'b0;
      front_q <= '0;
      swap_done_q <= 1'b0;
      lookup_data_q <= '0;
      lookup_data_valid_q <= '0;
    end else begin
      live_q <= 1'b1;
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      aw_addr_q <= aw_addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      bresp_q <= bresp_d;
      r_state_q <= r_state_d;
      ar_addr_q <= ar_addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      req_q <= req_d;
      pend_q <= pend_d;
      front_q <= front_d;
      swap_done_q <= swap_done_d;
      lookup_data_q <= lookup_data_d;
      lookup_data_valid_q <= lookup_valid;
    end
endmodule

// File: tb/tb_axil_palette_table.sv
// tb_axil_palette_table: directed and random checks of the palette table against a word-array model
module tb_axil_palette_table;
  logic aclk = 1'b0, areset = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [2:0] awprot = '0, arprot = '0;
  logic [3:0] wstrb = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, frame_sync = 0;
  logic awready, wready, bvalid, arready, rvalid, swap_done;
  logic [1:0] bresp, rresp, lookup_data_valid;
  logic [1:0] lookup_valid = '0;
  logic [15:0] lookup_index = '0;
  logic [31:0] lookup_data;
  logic [0:0] front_bank;
  logic [31:0] mm [256];
  logic [31:0] exp_ld = '0;
  int m_front = 0, m_req = 0;
  bit m_pend = 0;
  int checks = 0, errors = 0;

  axil_palette_table dut (
    .aclk(aclk), .areset(areset),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .frame_sync(frame_sync), .lookup_valid(lookup_valid), .lookup_index(lookup_index),
    .lookup_data(lookup_data), .lookup_data_valid(lookup_data_valid),
    .front_bank(front_bank), .swap_done(swap_done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_entry(input int bank, input int idx);
    logic [31:0] w;
    w = mm[bank*128 + idx/2];
    return (idx % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  function automatic void m_write(input int word, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) mm[word][8*i +: 8] = d[8*i +: 8];
  endfunction

  function automatic void m_ctrl(input int b);
    if (b != m_front) m_pend = 1;
    m_req = b;
  endfunction

  function automatic logic [31:0] m_ctrl_word();
    return {23'b0, m_pend, 6'b0, 2'(m_req)};
  endfunction

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int b_hold, input bit finish, output logic [1:0] resp);
    int cyc, lat, gap;
    bit a, b, aw_done, w_done;
    gap = lead < 0 ? -lead : lead;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = lead <= 0; wvalid = lead >= 0;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      a = awvalid && awready;
      b = wvalid && wready;
      @(posedge aclk); #1; cyc++;
      if (a) begin aw_done = 1; awvalid = 0; end
      if (b) begin w_done = 1; wvalid = 0; end
      if (cyc == gap) begin
        if (!aw_done) awvalid = 1;
        if (!w_done) wvalid = 1;
      end
    end
    awvalid = 0; wvalid = 0;
    check("aw_w_handshake", {aw_done, w_done}, 2'b11);
    lat = 1;
    while (!bvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
    check("write_latency", lat, 2);
    resp = bresp;
    if (finish) begin
      for (int i = 0; i < b_hold; i++) begin
        @(posedge aclk); #1;
        check("bvalid_hold", {bvalid, bresp}, {1'b1, resp});
      end
      bready = 1; @(posedge aclk); #1; bready = 0;
      check("bvalid_drop", bvalid, 0);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int lead, input logic [1:0] exp_r);
    logic [1:0] r;
    axi_write(addr, data, strb, lead, 0, 1, r);
    check("bresp", r, exp_r);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int cyc, lat;
    bit a;
    araddr = addr; arvalid = 1; cyc = 0; a = 0;
    while (!a && cyc < 50) begin a = arready; @(posedge aclk); #1; cyc++; end
    arvalid = 0;
    check("ar_handshake", a, 1);
    lat = 1;
    while (!rvalid && lat < 20) begin @(posedge aclk); #1; lat++; end
    check("read_latency", lat, 2);
    d = rdata; r = rresp;
    rready = 1; @(posedge aclk); #1; rready = 0;
    check("rvalid_drop", rvalid, 0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(addr, d, r);
    check(tag, d, exp_d);
    check("rresp", r, exp_r);
  endtask

  task automatic lookup(input logic [1:0] v, input logic [7:0] i0, input logic [7:0] i1);
    lookup_valid = v; lookup_index = {i1, i0};
    @(posedge aclk); #1;
    if (v[0]) exp_ld[15:0] = m_entry(m_front, int'(i0));
    if (v[1]) exp_ld[31:16] = m_entry(m_front, int'(i1));
    check("lookup_data", lookup_data, exp_ld);
    check("lookup_data_valid", lookup_data_valid, v);
    lookup_valid = '0;
  endtask

  task automatic pulse_frame();
    bit sd;
    sd = m_pend;
    frame_sync = 1; @(posedge aclk); #1; frame_sync = 0;
    if (m_pend) begin m_front = m_req; m_pend = 0; end
    check("swap_done", swap_done, sd);
    check("front_bank", front_bank, m_front);
    @(posedge aclk); #1;
    check("swap_done_clear", swap_done, 0);
  endtask

  initial begin
    logic [31:0] d, old, rd;
    logic [1:0] resp;
    int w, b;
    bit got_r, got_b, stale;
    repeat (3) @(posedge aclk); #1;
    check("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, swap_done, front_bank, lookup_data_valid}, 0);
    check("reset_data", rdata | lookup_data, 0);
    areset = 0;
    check("ready_low_at_release", {awready, wready, arready}, 0);
    @(posedge aclk); #1;
    check("ready_rise", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      wr(i*4, d, 4'hF, 0, 2'b00);
      m_write(i, d, 4'hF);
    end
    wr(32'h000, 32'hBEEF_1234, 4'hF, 0, 2'b00);
    m_write(0, 32'hBEEF_1234, 4'hF);
    rd_check("word0", 32'h000, 32'hBEEF_1234, 2'b00);
    lookup(2'b11, 8'd0, 8'd1);
    check("lookup_first_entries", lookup_data, 32'hBEEF_1234);
    wr(32'h004, 32'h0, 4'hF, 0, 2'b00);
    m_write(1, 32'h0, 4'hF);
    axi_write(32'h004, 32'hFFFF_FFFF, 4'b0100, 3, 4, 1, resp);
    check("strobe_bresp", resp, 2'b00);
    m_write(1, 32'hFFFF_FFFF, 4'b0100);
    rd_check("strobe_word", 32'h004, 32'h00FF_0000, 2'b00);
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      wr(32'h200 + k*4, d, 4'hF, k % 3 - 1, 2'b00);
      m_write(128 + k, d, 4'hF);
      lookup(2'b11, 8'(k), 8'(k + 100));
    end
    wr(32'h400, 32'h1, 4'hF, 0, 2'b00);
    m_ctrl(1);
    rd_check("ctrl_pending", 32'h400, 32'h101, 2'b00);
    pulse_frame();
    check("front_is_1", front_bank, 1);
    lookup(2'b11, 8'd3, 8'd14);
    rd_check("ctrl_swapped", 32'h400, 32'h001, 2'b00);
    pulse_frame();
    rd_check("oor_read", 32'h404, 32'h0, 2'b10);
    wr(32'h800, 32'hDEAD_BEEF, 4'hF, 0, 2'b10);
    rd_check("oor_no_alias", 32'h000, mm[0], 2'b00);
    rd_check("oor_ctrl_kept", 32'h400, m_ctrl_word(), 2'b00);
    old = mm[5]; d = ~old;
    awaddr = 32'h14; wdata = d; wstrb = 4'hF; araddr = 32'h14;
    awvalid = 1; wvalid = 1; arvalid = 1;
    check("all_ready", {awready, wready, arready}, 3'b111);
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    got_r = 0; got_b = 0; rd = '0;
    for (int k = 0; k < 6; k++) begin
      if (rvalid && !got_r) begin rd = rdata; got_r = 1; end
      if (bvalid) got_b = 1;
      @(posedge aclk); #1;
    end
    bready = 0; rready = 0;
    check("read_first_old", rd, old);
    check("read_first_both_resp", {got_r, got_b}, 2'b11);
    m_write(5, d, 4'hF);
    rd_check("reread_new", 32'h14, d, 2'b00);
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          w = $urandom_range(0, 255); d = $urandom; b = $urandom_range(0, 15);
          wr(w*4, d, 4'(b), int'($urandom_range(0, 4)) - 2, 2'b00);
          m_write(w, d, 4'(b));
        end
        1: begin
          w = $urandom_range(0, 255);
          rd_check("rand_read", w*4, mm[w], 2'b00);
        end
        2: lookup(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        default: begin
          b = $urandom_range(0, 1);
          wr(32'h400, 32'(b), 4'hF, 0, 2'b00);
          m_ctrl(b);
          rd_check("rand_ctrl", 32'h400, m_ctrl_word(), 2'b00);
          if ($urandom_range(0, 1) == 1) pulse_frame();
        end
      endcase
    end
    if (m_front == 0) begin
      wr(32'h400, 32'h1, 4'hF, 0, 2'b00);
      m_ctrl(1);
      pulse_frame();
    end
    d = $urandom;
    axi_write(32'h18, d, 4'hF, 0, 0, 0, resp);
    m_write(6, d, 4'hF);
    lookup_valid = 2'b11; lookup_index = {8'd9, 8'd2};
    @(posedge aclk); #1;
    check("bvalid_before_reset", {bvalid, lookup_data_valid, front_bank}, 4'b1111);
    #2 areset = 1;
    #1;
    check("async_reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, swap_done, front_bank, lookup_data_valid}, 0);
    check("async_reset_data", rdata | lookup_data, 0);
    lookup_valid = '0;
    repeat (2) @(posedge aclk); #1;
    areset = 0;
    m_front = 0; m_req = 0; m_pend = 0; exp_ld = '0;
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      if (bvalid || rvalid) stale = 1;
      @(posedge aclk); #1;
    end
    check("no_stale_response", stale, 0);
    check("front_after_reset", front_bank, 0);
    rd_check("ctrl_after_reset", 32'h400, 32'h0, 2'b00);
    rd_check("kept_after_reset", 32'h18, d, 2'b00);
    lookup(2'b11, 8'd12, 8'd13);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
